// File: rtl/debounce_pkg.sv
// Shared constants, FSM state encoding and parameter-range helper for the
// debouncer array and its per-channel filter.
package debounce_pkg;

  // Default configuration of one debouncer array.
  localparam int DEF_N_CH          = 4;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_CNT_W         = 16;
  localparam int DEF_STABLE_CYCLES = 10;
  localparam int DEF_HOLD_CYCLES   = 0;

  // Per-channel filter state. Bit 1 is the debounced level, so the two
  // "high side" states share it and the level can never disagree with it.
  typedef enum logic [1:0] {
    ST_LOW       = 2'b00,
    ST_PEND_HIGH = 2'b01,
    ST_HIGH      = 2'b11,
    ST_PEND_LOW  = 2'b10
  } db_state_e;

  // True when value is representable as an unsigned counter of the given width.
  function automatic bit fits_counter(input longint value, input int width);
    return (value >= 64'sd0) && (value <= ((64'sd1 <<< width) - 64'sd1));
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser chain, symmetric stability filter,
// rise/fall strobes and a one-shot long-press strobe.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic noisy_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic hold_o,
  output logic rise_nxt_o,
  output logic fall_nxt_o
);

  // Counter compare points; the counters run 0..N-1 so N samples are seen.
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   =
    (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam bit               HOLD_EN     = (HOLD_CYCLES > 0);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;

  db_state_e              r_state;
  logic                   r_level;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_rise;
  logic                   r_fall;

  logic [CNT_W-1:0]       r_hcnt;
  logic                   r_held;
  logic                   r_hold;

  logic                   w_flip;
  logic                   w_rise_nxt;
  logic                   w_fall_nxt;
  logic                   w_hold_nxt;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], noisy_i};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Decide this cycle's level flip and strobes from the current sample.
  always_comb begin
    w_flip     = 1'b0;
    w_rise_nxt = 1'b0;
    w_fall_nxt = 1'b0;
    w_hold_nxt = 1'b0;
    if ((w_s != r_level) && (r_cnt == STABLE_LAST)) begin
      w_flip = 1'b1;
    end else begin
      w_flip = 1'b0;
    end
    w_rise_nxt = w_flip & w_s;
    w_fall_nxt = w_flip & ~w_s;
    if (HOLD_EN && r_level && !r_held && (r_hcnt == HOLD_LAST)) begin
      w_hold_nxt = 1'b1;
    end else begin
      w_hold_nxt = 1'b0;
    end
  end

  // Stability FSM: a pending state is left on any agreeing sample, or
  // crosses to the opposite level on the STABLE_CYCLES-th differing one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_LOW;
      r_level <= 1'b0;
      r_cnt   <= {CNT_W{1'b0}};
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= w_rise_nxt;
      r_fall <= w_fall_nxt;
      case (r_state)
        ST_LOW, ST_PEND_HIGH: begin
          if (!w_s) begin
            r_state <= ST_LOW;
            r_level <= 1'b0;
            r_cnt   <= {CNT_W{1'b0}};
          end else if (w_flip) begin
            r_state <= ST_HIGH;
            r_level <= 1'b1;
            r_cnt   <= {CNT_W{1'b0}};
          end else begin
            r_state <= ST_PEND_HIGH;
            r_level <= 1'b0;
            r_cnt   <= r_cnt + CNT_ONE;
          end
        end
        ST_HIGH, ST_PEND_LOW: begin
          if (w_s) begin
            r_state <= ST_HIGH;
            r_level <= 1'b1;
            r_cnt   <= {CNT_W{1'b0}};
          end else if (w_flip) begin
            r_state <= ST_LOW;
            r_level <= 1'b0;
            r_cnt   <= {CNT_W{1'b0}};
          end else begin
            r_state <= ST_PEND_LOW;
            r_level <= 1'b1;
            r_cnt   <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= ST_LOW;
          r_level <= 1'b0;
          r_cnt   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Long-press timer: counts while high and not yet fired, freezes after
  // firing, and is re-armed only by a debounced release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hcnt <= {CNT_W{1'b0}};
      r_held <= 1'b0;
      r_hold <= 1'b0;
    end else begin
      r_hold <= w_hold_nxt;
      if (w_fall_nxt) begin
        r_hcnt <= {CNT_W{1'b0}};
        r_held <= 1'b0;
      end else if (w_hold_nxt) begin
        r_held <= 1'b1;
      end else if (HOLD_EN && r_level && !r_held) begin
        r_hcnt <= r_hcnt + CNT_ONE;
      end else begin
        r_hcnt <= r_hcnt;
      end
    end
  end

  assign level_o    = r_level;
  assign rise_o     = r_rise;
  assign fall_o     = r_fall;
  assign hold_o     = r_hold;
  assign rise_nxt_o = w_rise_nxt;
  assign fall_nxt_o = w_fall_nxt;

endmodule

// File: rtl/debouncer_array.sv
// N independent debounced inputs with a shared "something changed" strobe.
module debouncer_array
  import debounce_pkg::*;
#(
  parameter int N_CH          = DEF_N_CH,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_CH-1:0] noisy_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o,
  output logic [N_CH-1:0] hold_o,
  output logic            any_change_o
);

  // Reject configurations the counters cannot represent.
  if (N_CH < 1) begin : g_chk_n_ch
    $error("debouncer_array: N_CH must be at least 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("debouncer_array: SYNC_STAGES must be at least 2");
  end
  if ((CNT_W < 1) || (CNT_W > 32)) begin : g_chk_cnt_w
    $error("debouncer_array: CNT_W must be in 1..32");
  end
  if ((STABLE_CYCLES < 1) || !fits_counter(longint'(STABLE_CYCLES), CNT_W)) begin : g_chk_stable
    $error("debouncer_array: STABLE_CYCLES must be in 1..2**CNT_W-1");
  end
  if ((HOLD_CYCLES < 0) || !fits_counter(longint'(HOLD_CYCLES), CNT_W)) begin : g_chk_hold
    $error("debouncer_array: HOLD_CYCLES must be in 0..2**CNT_W-1");
  end

  logic [N_CH-1:0] w_rise_nxt;
  logic [N_CH-1:0] w_fall_nxt;
  logic            r_any_change;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .CNT_W        (CNT_W),
      .STABLE_CYCLES(STABLE_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .noisy_i   (noisy_i[g]),
      .level_o   (level_o[g]),
      .rise_o    (rise_o[g]),
      .fall_o    (fall_o[g]),
      .hold_o    (hold_o[g]),
      .rise_nxt_o(w_rise_nxt[g]),
      .fall_nxt_o(w_fall_nxt[g])
    );
  end

  // Register the OR of next-cycle strobes so it lines up with rise_o/fall_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_any_change <= 1'b0;
    end else begin
      r_any_change <= |(w_rise_nxt | w_fall_nxt);
    end
  end

  assign any_change_o = r_any_change;

endmodule

// File: tb/tb_debouncer_array.sv
// Bench for debouncer_array: directed scenarios plus random bouncing inputs,
// checked against an edge-by-edge reference model of the filtering rules.
module tb_debouncer_array;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] noisy;

  logic [3:0] lvl0, rise0, fall0, hold0;
  logic       any0;
  logic [1:0] lvl1, rise1, fall1, hold1;
  logic       any1;

  int n_checks = 0;
  int n_errors = 0;

  // Model parameters: [0] default-style instance, [1] fast boundary instance.
  int P_NCH  [2] = '{4, 2};
  int P_SYNC [2] = '{2, 3};
  int P_STAB [2] = '{10, 1};
  int P_HOLD [2] = '{50, 1};

  bit         m_level  [2][4];
  int         m_run    [2][4];
  int         m_rise_t [2][4];
  bit         m_rise   [2][4];
  bit         m_fall   [2][4];
  bit         m_hold   [2][4];
  bit         m_any    [2];
  logic [3:0] m_hist[$];
  int         edge_no;

  int         cnt, rise_e, hold_e;
  logic [16:0] act;
  bit         tgt   [4];
  int         timer [4];

  always #5 clk = ~clk;

  debouncer_array #(
    .N_CH(4), .SYNC_STAGES(2), .CNT_W(16), .STABLE_CYCLES(10), .HOLD_CYCLES(50)
  ) u_dut0 (
    .clk_i(clk), .rst_i(rst), .noisy_i(noisy),
    .level_o(lvl0), .rise_o(rise0), .fall_o(fall0), .hold_o(hold0),
    .any_change_o(any0)
  );

  debouncer_array #(
    .N_CH(2), .SYNC_STAGES(3), .CNT_W(4), .STABLE_CYCLES(1), .HOLD_CYCLES(1)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst), .noisy_i(noisy[1:0]),
    .level_o(lvl1), .rise_o(rise1), .fall_o(fall1), .hold_o(hold1),
    .any_change_o(any1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_any[d] = 1'b0;
      for (int c = 0; c < 4; c++) begin
        m_level[d][c]  = 1'b0;
        m_run[d][c]    = 0;
        m_rise_t[d][c] = 0;
        m_rise[d][c]   = 1'b0;
        m_fall[d][c]   = 1'b0;
        m_hold[d][c]   = 1'b0;
      end
    end
    m_hist.delete();
  endtask

  // One clock edge: the filter sees the input sampled SYNC edges earlier; a
  // level flips after STABLE consecutive disagreeing samples; hold fires
  // exactly HOLD edges after the rise if the level is still high.
  task automatic model_edge();
    logic [3:0] v;
    bit s, prev;
    edge_no++;
    for (int d = 0; d < 2; d++) begin
      m_any[d] = 1'b0;
      for (int c = 0; c < P_NCH[d]; c++) begin
        if (m_hist.size() >= P_SYNC[d]) begin
          v = m_hist[m_hist.size() - P_SYNC[d]];
          s = v[c];
        end else begin
          s = 1'b0;
        end
        prev = m_level[d][c];
        m_rise[d][c] = 1'b0;
        m_fall[d][c] = 1'b0;
        m_hold[d][c] = 1'b0;
        if (prev && (P_HOLD[d] > 0) && ((edge_no - m_rise_t[d][c]) == P_HOLD[d]))
          m_hold[d][c] = 1'b1;
        if (s != prev) begin
          m_run[d][c]++;
          if (m_run[d][c] == P_STAB[d]) begin
            m_level[d][c] = s;
            m_run[d][c]   = 0;
            if (s) begin
              m_rise[d][c]   = 1'b1;
              m_rise_t[d][c] = edge_no;
            end else begin
              m_fall[d][c] = 1'b1;
            end
          end
        end else begin
          m_run[d][c] = 0;
        end
        m_any[d] = m_any[d] | m_rise[d][c] | m_fall[d][c];
      end
    end
    m_hist.push_back(noisy);
    if (m_hist.size() > 8) void'(m_hist.pop_front());
  endtask

  task automatic compare_all();
    logic [3:0] el, er, ef, eh;
    for (int d = 0; d < 2; d++) begin
      el = 4'd0; er = 4'd0; ef = 4'd0; eh = 4'd0;
      for (int c = 0; c < P_NCH[d]; c++) begin
        el[c] = m_level[d][c];
        er[c] = m_rise[d][c];
        ef[c] = m_fall[d][c];
        eh[c] = m_hold[d][c];
      end
      if (d == 0) begin
        check_eq("d0_level", lvl0, el);
        check_eq("d0_rise", rise0, er);
        check_eq("d0_fall", fall0, ef);
        check_eq("d0_hold", hold0, eh);
        check_eq("d0_any", any0, m_any[0]);
      end else begin
        check_eq("d1_level", lvl1, el[1:0]);
        check_eq("d1_rise", rise1, er[1:0]);
        check_eq("d1_fall", fall1, ef[1:0]);
        check_eq("d1_hold", hold1, eh[1:0]);
        check_eq("d1_any", any1, m_any[1]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    @(negedge clk);
    compare_all();
    act = act | {any0, hold0, fall0, rise0, lvl0};
  endtask

  initial begin
    rst     = 1'b1;
    noisy   = 4'd0;
    edge_no = 0;
    act     = 17'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("reset_d0", {any0, hold0, fall0, rise0, lvl0}, 32'd0);
    check_eq("reset_d1", {any1, hold1, fall1, rise1, lvl1}, 32'd0);
    rst = 1'b0;

    // Quiet after reset release.
    repeat (100) step();
    check_eq("quiet_100", act, 32'd0);

    // Clean step on ch0: level and strobe exactly 12 edges later.
    noisy[0] = 1'b1;
    repeat (11) step();
    check_eq("ch0_lvl_at11", lvl0[0], 1'b0);
    step();
    check_eq("ch0_lvl_at12", lvl0, 4'b0001);
    check_eq("ch0_rise", rise0, 4'b0001);
    check_eq("ch0_any", any0, 1'b1);
    step();
    check_eq("ch0_rise_off", rise0, 4'b0000);
    check_eq("ch0_any_off", any0, 1'b0);

    // Glitch on ch1 after 9 high cycles restarts the count.
    noisy[1] = 1'b1;
    repeat (9) step();
    noisy[1] = 1'b0;
    step();
    noisy[1] = 1'b1;
    repeat (11) step();
    check_eq("ch1_no_early", lvl0[1], 1'b0);
    step();
    check_eq("ch1_lvl", lvl0[1], 1'b1);
    check_eq("ch1_rise", rise0, 4'b0010);

    // Release of ch0.
    noisy[0] = 1'b0;
    repeat (11) step();
    check_eq("ch0_pre_fall", lvl0[0], 1'b1);
    step();
    check_eq("ch0_fall_lvl", lvl0[0], 1'b0);
    check_eq("ch0_fall", fall0, 4'b0001);
    step();
    check_eq("ch0_fall_off", fall0, 4'b0000);

    // Long press on ch2: one hold pulse, 50 edges after the rise, twice.
    for (int p = 0; p < 2; p++) begin
      noisy[2] = 1'b1;
      cnt = 0; rise_e = -1000; hold_e = -2000;
      for (int i = 0; i < 200; i++) begin
        step();
        if (rise0[2]) rise_e = i;
        if (hold0[2]) begin
          cnt++;
          hold_e = i;
        end
      end
      check_eq(p == 0 ? "hold_count1" : "hold_count2", cnt, 1);
      check_eq(p == 0 ? "hold_delay1" : "hold_delay2", hold_e - rise_e, 50);
      noisy[2] = 1'b0;
      repeat (30) step();
    end

    // Reset while ch3 is pending (cnt = 7) with ch1 stably high.
    noisy = 4'b0010;
    repeat (20) step();
    check_eq("pre_rst_lvl", lvl0, 4'b0010);
    noisy[3] = 1'b1;
    repeat (9) step();
    rst = 1'b1;
    #1;
    check_eq("rst_async_d0", {any0, hold0, fall0, rise0, lvl0}, 32'd0);
    check_eq("rst_async_d1", {any1, hold1, fall1, rise1, lvl1}, 32'd0);
    model_reset();
    act = 17'd0;
    repeat (3) step();
    check_eq("rst_no_strobe", act, 32'd0);
    rst = 1'b0;
    repeat (11) step();
    check_eq("post_rst_quiet", lvl0, 4'b0000);
    step();
    check_eq("post_rst_rise", rise0, 4'b1010);
    check_eq("post_rst_lvl", lvl0, 4'b1010);

    // Random bouncing inputs with occasional resets.
    for (int c = 0; c < 4; c++) begin
      tgt[c]   = noisy[c];
      timer[c] = $urandom_range(3, 120);
    end
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (timer[c] == 0) begin
          tgt[c]   = ~tgt[c];
          timer[c] = $urandom_range(3, 120);
        end else begin
          timer[c]--;
        end
        noisy[c] = ($urandom_range(0, 9) == 0) ? ~tgt[c] : tgt[c];
      end
      rst = ($urandom_range(0, 799) == 0);
      step();
    end
    rst = 1'b0;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
